// File: rtl/accumulator.sv
// Per-column result collector: sums systolic-array column outputs over PASSES
// passes into a two-entry tile, then holds it with full until the buffer drains it.
module accumulator #(
  parameter int DATA_W = 32,
  parameter int PASSES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] acc_in,
  input  logic              drain,
  output logic [DATA_W-1:0] acc_mem_0,
  output logic [DATA_W-1:0] acc_mem_1,
  output logic              full,
  output logic              overflow
);

  typedef enum logic [1:0] {
    FILL0,
    FILL1,
    FULL
  } state_t;

  localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);

  state_t            state, state_nx;
  logic [7:0]        pass, pass_nx;
  logic [DATA_W-1:0] entry0_nx, entry1_nx;
  logic              overflow_nx;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nx    = state;
    pass_nx     = pass;
    entry0_nx   = acc_mem_0;
    entry1_nx   = acc_mem_1;
    overflow_nx = overflow;

    case (state)
      FILL0: begin
        if (valid_in) begin
          entry0_nx = (pass == 8'd0) ? acc_in : acc_mem_0 + acc_in;
          state_nx  = FILL1;
        end
      end
      FILL1: begin
        if (valid_in) begin
          entry1_nx = (pass == 8'd0) ? acc_in : acc_mem_1 + acc_in;
          if (pass == LAST_PASS) begin
            state_nx = FULL;
          end else begin
            state_nx = FILL0;
            pass_nx  = pass + 8'd1;
          end
        end
      end
      FULL: begin
        if (drain) begin
          // The buffer captures the old tile on this edge; a coincident
          // sample becomes the pass-0 write of the next tile.
          pass_nx = 8'd0;
          if (valid_in) begin
            entry0_nx = acc_in;
            state_nx  = FILL1;
          end else begin
            state_nx = FILL0;
          end
        end else if (valid_in) begin
          overflow_nx = 1'b1;
        end
      end
      default: begin
        state_nx = FILL0;
        pass_nx  = 8'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the entry registers are cleared on reset because the tile values
  // are visible outputs that must read zero while reset is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FILL0;
      pass      <= 8'd0;
      acc_mem_0 <= '0;
      acc_mem_1 <= '0;
      full      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nx;
      pass      <= pass_nx;
      acc_mem_0 <= entry0_nx;
      acc_mem_1 <= entry1_nx;
      full      <= (state_nx == FULL);
      overflow  <= overflow_nx;
    end
  end

endmodule
